// File: rtl/switch_select_debounce.sv
// switch_select_debounce: synchronize and debounce two buttons into a wrapping 2-bit LED select with a change strobe
module switch_select_debounce #(
   parameter int DEBOUNCE_LIMIT = 250000
) (
   input  logic       i_Clk,
   input  logic       i_Rst_L,
   input  logic       i_Switch_1,
   input  logic       i_Switch_2,
   output logic       o_Switch_1,
   output logic       o_Switch_2,
   output logic [1:0] o_Select,
   output logic       o_Select_Change
);
   localparam int CW = $clog2(DEBOUNCE_LIMIT + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_LIMIT - 1);
   logic [1:0] meta, sync, level, prev, press;
   logic [1:0] sel_next;
   logic [CW-1:0] count [2];
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         meta <= '0;
         sync <= '0;
      end else begin
         meta <= {i_Switch_2, i_Switch_1};
         sync <= meta;
      end
   end
   always_ff @(posedge i_Clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!i_Rst_L) begin
            count[i] <= '0;
            level[i] <= 1'b0;
         end else if (sync[i] == level[i]) begin
            count[i] <= '0;
         end else if (count[i] == LAST) begin
            count[i] <= '0;
            level[i] <= sync[i];
         end else begin
            count[i] <= count[i] + 1'b1;
         end
      end
   end
   assign press = level & ~prev;
   always_comb begin
      sel_next = press == 2'b01 ? o_Select + 2'd1 :
                 press == 2'b10 ? o_Select - 2'd1 : o_Select;
   end
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         prev            <= '0;
         o_Select        <= '0;
         o_Select_Change <= 1'b0;
      end else begin
         prev            <= level;
         o_Select        <= sel_next;
         o_Select_Change <= sel_next != o_Select;
      end
   end
   assign o_Switch_1 = level[0];
   assign o_Switch_2 = level[1];
endmodule

// File: tb/tb_switch_select_debounce.sv
// tb_switch_select_debounce: scoreboard-driven bench for the switch select debounce stage with DEBOUNCE_LIMIT=4
module tb_switch_select_debounce;
   logic       clk;
   logic       rst_n;
   logic       sw1, sw2;
   logic       o_sw1, o_sw2;
   logic [1:0] o_sel;
   logic       o_chg;
   logic [1:0] exp_sel;
   logic [1:0] sb [$];
   int compared, mismatched, strobes;

   switch_select_debounce #(.DEBOUNCE_LIMIT(4)) dut (
      .i_Clk(clk),
      .i_Rst_L(rst_n),
      .i_Switch_1(sw1),
      .i_Switch_2(sw2),
      .o_Switch_1(o_sw1),
      .o_Switch_2(o_sw2),
      .o_Select(o_sel),
      .o_Select_Change(o_chg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // every strobe must match the oldest expected select value
   always @(negedge clk) begin
      if (o_chg === 1'b1) begin
         logic [1:0] e;
         strobes++;
         compared++;
         if (sb.size() == 0) begin
            mismatched++;
            $display("FAIL strobe_unexpected: o_Select=%0d with no change expected", o_sel);
         end else begin
            e = sb.pop_front();
            if (o_sel !== e) begin
               mismatched++;
               $display("FAIL strobe_value: o_Select=%0d expected %0d", o_sel, e);
            end
         end
      end
   end

   task automatic press(input bit up);
      if (up) sw1 = 1'b1;
      else sw2 = 1'b1;
      exp_sel = up ? exp_sel + 2'd1 : exp_sel - 2'd1;
      sb.push_back(exp_sel);
      repeat (10) @(negedge clk);
      sw1 = 1'b0;
      sw2 = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      sw1 = 1'b1;
      sw2 = 1'b1;
      exp_sel = 2'd0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         compared++;
         if ({o_sw1, o_sw2, o_sel, o_chg} !== 5'b0) begin
            mismatched++;
            $display("FAIL reset_outputs: sw1=%b sw2=%b sel=%0d chg=%b expected all 0", o_sw1, o_sw2, o_sel, o_chg);
         end
      end
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      compared++;
      if (o_sw1 !== 1'b0 || o_sw2 !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_early_switch: sw1=%b sw2=%b expected 0 0", o_sw1, o_sw2);
      end
      @(negedge clk);
      compared++;
      if (o_sw1 !== 1'b1 || o_sw2 !== 1'b1) begin
         mismatched++;
         $display("FAIL reset_switch_rise: sw1=%b sw2=%b expected 1 1", o_sw1, o_sw2);
      end
      repeat (4) @(negedge clk);
      compared++;
      if (o_sel !== 2'd0 || strobes !== 0) begin
         mismatched++;
         $display("FAIL reset_both_held: sel=%0d strobes=%0d expected 0 0", o_sel, strobes);
      end
      sw1 = 1'b0;
      sw2 = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_single_advance();
      int s0;
      logic [1:0] old;
      s0 = strobes;
      old = exp_sel;
      sw1 = 1'b1;
      exp_sel = exp_sel + 2'd1;
      sb.push_back(exp_sel);
      repeat (5) @(negedge clk);
      compared++;
      if (o_sw1 !== 1'b0) begin
         mismatched++;
         $display("FAIL adv_early: o_Switch_1=%b expected 0", o_sw1);
      end
      @(negedge clk);
      compared++;
      if (o_sw1 !== 1'b1 || o_sel !== old) begin
         mismatched++;
         $display("FAIL adv_debounced: o_Switch_1=%b sel=%0d expected 1 %0d", o_sw1, o_sel, old);
      end
      @(negedge clk);
      compared++;
      if (o_sel !== exp_sel || o_chg !== 1'b1) begin
         mismatched++;
         $display("FAIL adv_update: sel=%0d chg=%b expected %0d 1", o_sel, o_chg, exp_sel);
      end
      @(negedge clk);
      compared++;
      if (o_chg !== 1'b0) begin
         mismatched++;
         $display("FAIL adv_strobe_width: chg=%b expected 0", o_chg);
      end
      repeat (12) @(negedge clk);
      compared++;
      if (o_sel !== exp_sel || strobes - s0 !== 1) begin
         mismatched++;
         $display("FAIL adv_hold: sel=%0d strobes=%0d expected %0d 1", o_sel, strobes - s0, exp_sel);
      end
      sw1 = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_wrap();
      logic [1:0] want [4];
      int s0;
      want = '{2'd1, 2'd2, 2'd3, 2'd0};
      s0 = strobes;
      press(1'b0);
      compared++;
      if (o_sel !== 2'd0) begin
         mismatched++;
         $display("FAIL wrap_start: sel=%0d expected 0", o_sel);
      end
      for (int i = 0; i < 4; i++) begin
         press(1'b1);
         compared++;
         if (o_sel !== want[i]) begin
            mismatched++;
            $display("FAIL wrap_up%0d: sel=%0d expected %0d", i, o_sel, want[i]);
         end
      end
      press(1'b0);
      compared++;
      if (o_sel !== 2'd3) begin
         mismatched++;
         $display("FAIL wrap_down: sel=%0d expected 3", o_sel);
      end
      press(1'b1);
      compared++;
      if (o_sel !== 2'd0 || strobes - s0 !== 7) begin
         mismatched++;
         $display("FAIL wrap_strobes: sel=%0d strobes=%0d expected 0 7", o_sel, strobes - s0);
      end
   endtask

   task automatic test_glitch();
      logic [15:0] pat;
      logic [7:0] bounce;
      int s0;
      s0 = strobes;
      pat = 16'b0000_0000_0111_0111;
      for (int i = 0; i < 16; i++) begin
         sw1 = pat[i];
         @(negedge clk);
         compared++;
         if (o_sw1 !== 1'b0) begin
            mismatched++;
            $display("FAIL glitch_cycle%0d: o_Switch_1=%b expected 0", i, o_sw1);
         end
      end
      compared++;
      if (o_sel !== exp_sel || strobes !== s0) begin
         mismatched++;
         $display("FAIL glitch_select: sel=%0d strobes=%0d expected %0d 0", o_sel, strobes - s0, exp_sel);
      end
      sw1 = 1'b1;
      exp_sel = exp_sel + 2'd1;
      sb.push_back(exp_sel);
      repeat (10) @(negedge clk);
      bounce = 8'b1000_1000;
      for (int i = 0; i < 8; i++) begin
         sw1 = bounce[i];
         @(negedge clk);
         compared++;
         if (o_sw1 !== 1'b1) begin
            mismatched++;
            $display("FAIL bounce_cycle%0d: o_Switch_1=%b expected 1", i, o_sw1);
         end
      end
      sw1 = 1'b0;
      repeat (10) @(negedge clk);
      compared++;
      if (o_sel !== exp_sel || strobes - s0 !== 1) begin
         mismatched++;
         $display("FAIL bounce_select: sel=%0d strobes=%0d expected %0d 1", o_sel, strobes - s0, exp_sel);
      end
      press(1'b0);
   endtask

   task automatic test_simultaneous();
      int s0;
      s0 = strobes;
      sw1 = 1'b1;
      sw2 = 1'b1;
      repeat (20) @(negedge clk);
      compared++;
      if (o_sw1 !== 1'b1 || o_sw2 !== 1'b1 || o_sel !== exp_sel || strobes !== s0) begin
         mismatched++;
         $display("FAIL simul_both: sw1=%b sw2=%b sel=%0d strobes=%0d expected 1 1 %0d 0", o_sw1, o_sw2, o_sel, strobes - s0, exp_sel);
      end
      sw1 = 1'b0;
      sw2 = 1'b0;
      repeat (10) @(negedge clk);
      compared++;
      if (o_sel !== 2'd0) begin
         mismatched++;
         $display("FAIL stagger_start: sel=%0d expected 0", o_sel);
      end
      sw1 = 1'b1;
      exp_sel = exp_sel + 2'd1;
      sb.push_back(exp_sel);
      repeat (10) @(negedge clk);
      compared++;
      if (o_sel !== 2'd1) begin
         mismatched++;
         $display("FAIL stagger_first: sel=%0d expected 1", o_sel);
      end
      sw2 = 1'b1;
      exp_sel = exp_sel - 2'd1;
      sb.push_back(exp_sel);
      repeat (7) @(negedge clk);
      compared++;
      if (o_sel !== 2'd0 || o_chg !== 1'b1) begin
         mismatched++;
         $display("FAIL stagger_second: sel=%0d chg=%b expected 0 1", o_sel, o_chg);
      end
      repeat (13) @(negedge clk);
      sw1 = 1'b0;
      sw2 = 1'b0;
      repeat (10) @(negedge clk);
      compared++;
      if (strobes - s0 !== 2) begin
         mismatched++;
         $display("FAIL stagger_strobes: strobes=%0d expected 2", strobes - s0);
      end
   endtask

   task automatic test_reset_mid();
      press(1'b1);
      press(1'b1);
      compared++;
      if (o_sel !== 2'd2) begin
         mismatched++;
         $display("FAIL midrst_setup: sel=%0d expected 2", o_sel);
      end
      sw1 = 1'b1;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      sb.delete();
      exp_sel = 2'd0;
      @(negedge clk);
      rst_n = 1'b1;
      compared++;
      if (o_sel !== 2'd0 || o_sw1 !== 1'b0 || o_sw2 !== 1'b0 || o_chg !== 1'b0) begin
         mismatched++;
         $display("FAIL midrst_clear: sel=%0d sw1=%b sw2=%b chg=%b expected 0 0 0 0", o_sel, o_sw1, o_sw2, o_chg);
      end
      exp_sel = 2'd1;
      sb.push_back(exp_sel);
      repeat (6) @(negedge clk);
      compared++;
      if (o_sw1 !== 1'b1 || o_sel !== 2'd0) begin
         mismatched++;
         $display("FAIL midrst_held_debounce: sw1=%b sel=%0d expected 1 0", o_sw1, o_sel);
      end
      @(negedge clk);
      compared++;
      if (o_sel !== 2'd1 || o_chg !== 1'b1) begin
         mismatched++;
         $display("FAIL midrst_held_press: sel=%0d chg=%b expected 1 1", o_sel, o_chg);
      end
      sw1 = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   initial begin
      compared = 0;
      mismatched = 0;
      strobes = 0;
      test_reset();
      test_single_advance();
      test_wrap();
      test_glitch();
      test_simultaneous();
      test_reset_mid();
      compared++;
      if (sb.size() != 0) begin
         mismatched++;
         $display("FAIL scoreboard_drain: %0d expected changes never seen, expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded 200000 time units, expected completion");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/switch_select_debounce.md
# switch_select_debounce

Upstream input stage for the selective-blink LED path. Synchronizes and debounces the two push-button switches, converts clean presses into a 2-bit LED selection index, and presents it to the LED demultiplexer stage. It replaces raw switch wiring into the demux: the demux receives a stable, registered select and a one-cycle change strobe.

## Interface
- DEBOUNCE_LIMIT, 250000, consecutive stable cycles required before a switch level is accepted (10 ms at 25 MHz); legal range ≥ 1
- i_Clk  input  1  system clock; all logic on rising edge
- i_Rst_L  input  1  reset; synchronous and active-low
- i_Switch_1  input  1  raw, asynchronous push button; high = pressed; press advances selection
- i_Switch_2  input  1  raw, asynchronous push button; high = pressed; press retreats selection
- o_Switch_1  output  1  debounced level of switch 1
- o_Switch_2  output  1  debounced level of switch 2
- o_Select  output  2  current LED index 0..3, to demux
- o_Select_Change  output  1  one-cycle strobe, high in the cycle o_Select takes a new value

## Operation
- Reset (i_Rst_L low at a rising edge): synchronizer flops, debounce counters, o_Switch_1/2, o_Select, o_Select_Change and edge-detect history all go to 0. Reset has priority over every other action, including mid-count and mid-update.
- Synchronizer: each switch passes through two flops before any other use; only the second-flop output (sync level) is used.
- Debounce, per switch, independent:
  - Counter width $clog2(DEBOUNCE_LIMIT+1); never wraps.
  - sync level == debounced level: counter cleared to 0.
  - sync level != debounced level: counter increments; on the cycle the counter reaches DEBOUNCE_LIMIT-1 and the mismatch persists, the debounced level flips and the counter clears.
  - Any single-cycle return to the debounced level before the limit clears the counter (glitch rejected).
- Press event: registered rising edge of a debounced level (previous 0, current 1). Releases generate no event.
- Select update, on the cycle after the debounced rise:
  - Switch 1 press only: o_Select = o_Select + 1, modulo 4 (3 -> 0).
  - Switch 2 press only: o_Select = o_Select - 1, modulo 4 (0 -> 3).
  - Both presses in the same cycle: no change, no strobe.
  - o_Select_Change high exactly in the cycles where o_Select changes, otherwise low.
- Holding a switch produces exactly one event per press.

## Timing
- Input change to sync level: 2 cycles.
- Sync level stable to debounced output flip: DEBOUNCE_LIMIT cycles.
- Total raw press (held stable) to o_Switch_n high: DEBOUNCE_LIMIT+2 cycles.
- o_Switch_n high to o_Select / o_Select_Change update: 1 cycle, so total DEBOUNCE_LIMIT+3.
- Strobe width: exactly 1 cycle.
- Presses on the two switches whose events land in different cycles are each applied, in order.
- Reset release: the first press event is possible no earlier than DEBOUNCE_LIMIT+3 cycles after i_Rst_L returns high with the switch already held. A switch held through reset counts as a new press once it is debounced.

## Test plan
All scenarios use DEBOUNCE_LIMIT=4.
- Reset: drive i_Rst_L low for 3 cycles with both switches high, then release. All outputs are 0 during reset. o_Switch_1/2 go high 6 cycles after release, o_Select stays 0 (simultaneous press), and no strobe occurs.
- Single advance: hold i_Switch_1 high for 20 cycles. o_Switch_1 rises at +6, o_Select goes 0 -> 1 at +7 with a 1-cycle o_Select_Change, and no further change while held.
- Wrap both ways: four clean switch-1 presses give o_Select 1,2,3,0. One switch-2 press from 0 gives 3. Each step produces exactly one strobe.
- Glitch rejection: pulse i_Switch_1 high for 3 cycles, low for 1, then high for 3. o_Switch_1 stays 0 and o_Select is unchanged. Bounce on release likewise does not alter o_Select.
- Simultaneous: both switches rise on the same edge and stay high. No o_Select change and no strobe. Then switch 2 press staggered by 10 cycles after switch 1 press (from 0) gives 1 then 0, with two strobes.
- Reset mid-operation: with o_Select=2 and a counter at 2, assert i_Rst_L low for 1 cycle. The next cycle shows o_Select=0, o_Switch_n=0, and no strobe.
